// File: rtl/cr_huf_comp_sc_short_pkg.sv
// cr_huf_compPKG: shared constants and types for the short-alphabet
// histogram scanner (cr_huf_comp_sc_short) and its output FIFO.
//   - HC_NUM_SYM / HC_NUM_QUAD : short-alphabet size and count-RAM quad count
//   - HC_FIFO_DEPTH            : output FIFO depth
//   - s_sc_is_short_intf       : consumer-facing word (4 symbols + counts + ids)
//   - sc_fifo_entry_t          : internal FIFO entry (quad address + raw counts)
package cr_huf_compPKG;

  localparam int HC_NUM_SYM    = 576;
  localparam int HC_NUM_QUAD   = HC_NUM_SYM / 4;
  localparam int HC_FIFO_DEPTH = 4;
  localparam int HC_CNT_W      = 20;
  localparam int HC_DAT_W      = 10;
  localparam int HC_SEQID_W    = 4;
  localparam int HC_QADDR_W    = 8;

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_SCAN,
    SC_DRAIN
  } sc_state_e;

  typedef struct packed {
    logic [HC_DAT_W-1:0]   short0;
    logic [HC_DAT_W-1:0]   short1;
    logic [HC_DAT_W-1:0]   short2;
    logic [HC_DAT_W-1:0]   short3;
    logic [HC_CNT_W-1:0]   cnt0;
    logic [HC_CNT_W-1:0]   cnt1;
    logic [HC_CNT_W-1:0]   cnt2;
    logic [HC_CNT_W-1:0]   cnt3;
    logic [HC_SEQID_W-1:0] seq_id;
    logic                  eob;
  } s_sc_is_short_intf;

  // Symbol indices are rebuilt from the quad address at the head, so the
  // FIFO only stores the address once per entry.
  typedef struct packed {
    logic [3:0]                 vld;
    logic                       last;
    logic [HC_QADDR_W-1:0]      addr;
    logic [3:0][HC_CNT_W-1:0]   cnt;
  } sc_fifo_entry_t;

endpackage

// File: rtl/cr_huf_comp_sc_short_ofifo.sv
// cr_huf_comp_sc_short_ofifo: HC_FIFO_DEPTH-entry output FIFO with a
// combinational head.
//   clk, rst_n   : clock, async active-low reset
//   wr_i         : push wr_data_i (caller guarantees space via credits)
//   rd_i         : pop request; ignored when empty
//   head_o       : current head entry (undefined when empty_o)
//   empty_o      : no entries held
//   count_o      : current occupancy
module cr_huf_comp_sc_short_ofifo
  import cr_huf_compPKG::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_i,
  input  sc_fifo_entry_t                    wr_data_i,
  input  logic                              rd_i,
  output sc_fifo_entry_t                    head_o,
  output logic                              empty_o,
  output logic [$clog2(HC_FIFO_DEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(HC_FIFO_DEPTH);

  sc_fifo_entry_t     mem_q [HC_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               pop;

  assign pop     = rd_i && (count_q != '0);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; occupancy alone decides whether
  // an entry is visible, and leaving the array reset-free keeps it as plain RAM.
  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_i, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cr_huf_comp_sc_short.sv
// cr_huf_comp_sc_short: scans the short-alphabet count RAM one quad per read,
// drops all-zero quads (except the final one) and presents surviving quads to
// the consumer through a small credit-controlled FIFO.
//   cnt_start/cnt_seq_id/cnt_eob : scan request and its tags (IDLE only)
//   cnt_ram_rd/addr/rdata        : count-RAM port, read data 1 cycle later
//   sc_is_short_vld/intf/last    : FIFO head, all-zero when FIFO empty
//   is_sc_short_rd               : consumer pop
//   sc_busy                      : scan or drain in progress
module cr_huf_comp_sc_short
  import cr_huf_compPKG::*;
#(
  parameter int NUM_SYM   = HC_NUM_SYM,
  parameter int CNT_WIDTH = HC_CNT_W,
  parameter int DAT_WIDTH = HC_DAT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cnt_start,
  input  logic [HC_SEQID_W-1:0]    cnt_seq_id,
  input  logic                     cnt_eob,
  output logic                     cnt_ram_rd,
  output logic [7:0]               cnt_ram_addr,
  input  logic [4*CNT_WIDTH-1:0]   cnt_ram_rdata,
  output logic [3:0]               sc_is_short_vld,
  output s_sc_is_short_intf        sc_is_short_intf,
  output logic                     sc_is_short_last,
  input  logic                     is_sc_short_rd,
  output logic                     sc_busy
);

  localparam logic [7:0] LAST_ADDR = 8'(NUM_SYM / 4 - 1);

  sc_state_e               state_q;
  logic [7:0]              addr_q;
  logic [HC_SEQID_W-1:0]   seq_id_q;
  logic                    eob_q;
  logic                    inflight_q;
  logic [7:0]              infl_addr_q;
  logic                    infl_last_q;

  sc_fifo_entry_t          wr_entry;
  sc_fifo_entry_t          head;
  logic                    fifo_wr;
  logic                    fifo_empty;
  logic [$clog2(HC_FIFO_DEPTH):0] fifo_count;
  logic                    issue;
  logic                    pop;
  logic [DAT_WIDTH-1:0]    short_idx [4];

  // Credit: whatever is queued plus what is still in flight must leave room
  // for the read issued now, with one slot of slack for the returning data.
  assign issue = (state_q == SC_SCAN) &&
                 (({1'b0, fifo_count} + {3'b000, inflight_q}) <= 4'd2);
  assign pop   = is_sc_short_rd && !fifo_empty;

  assign cnt_ram_rd   = issue;
  assign cnt_ram_addr = addr_q;
  assign sc_busy      = (state_q != SC_IDLE);

  // Final quad is always queued so the consumer sees an explicit last word.
  assign fifo_wr = inflight_q && ((|cnt_ram_rdata) || infl_last_q);

  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_entry      = '0;
    wr_entry.last = infl_last_q;
    wr_entry.addr = infl_addr_q;
    for (int i = 0; i < 4; i++) begin
      wr_entry.cnt[i] = cnt_ram_rdata[i*CNT_WIDTH +: CNT_WIDTH];
      wr_entry.vld[i] = |cnt_ram_rdata[i*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  cr_huf_comp_sc_short_ofifo u_ofifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_i      (fifo_wr),
    .wr_data_i (wr_entry),
    .rd_i      (is_sc_short_rd),
    .head_o    (head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) short_idx[i] = DAT_WIDTH'({head.addr, 2'(i)});
    sc_is_short_vld  = '0;
    sc_is_short_last = 1'b0;
    sc_is_short_intf = '0;
    if (!fifo_empty) begin
      sc_is_short_vld         = head.vld;
      sc_is_short_last        = head.last;
      sc_is_short_intf.short0 = short_idx[0];
      sc_is_short_intf.short1 = short_idx[1];
      sc_is_short_intf.short2 = short_idx[2];
      sc_is_short_intf.short3 = short_idx[3];
      sc_is_short_intf.cnt0   = head.cnt[0];
      sc_is_short_intf.cnt1   = head.cnt[1];
      sc_is_short_intf.cnt2   = head.cnt[2];
      sc_is_short_intf.cnt3   = head.cnt[3];
      sc_is_short_intf.seq_id = seq_id_q;
      sc_is_short_intf.eob    = eob_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SC_IDLE;
      addr_q      <= '0;
      seq_id_q    <= '0;
      eob_q       <= 1'b0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        infl_addr_q <= addr_q;
        infl_last_q <= (addr_q == LAST_ADDR);
        addr_q      <= addr_q + 8'd1;
      end
      unique case (state_q)
        SC_IDLE: begin
          if (cnt_start) begin
            state_q  <= SC_SCAN;
            addr_q   <= '0;
            seq_id_q <= cnt_seq_id;
            eob_q    <= cnt_eob;
          end
        end
        SC_SCAN: begin
          if (issue && (addr_q == LAST_ADDR)) state_q <= SC_DRAIN;
        end
        SC_DRAIN: begin
          if (pop && head.last) state_q <= SC_IDLE;
        end
        default: state_q <= SC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_sc_short.sv
module tb_cr_huf_comp_sc_short;
  import cr_huf_compPKG::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cnt_start = 1'b0;
  logic [HC_SEQID_W-1:0] cnt_seq_id = '0;
  logic                  cnt_eob = 1'b0;
  logic                  cnt_ram_rd;
  logic [7:0]            cnt_ram_addr;
  logic [4*HC_CNT_W-1:0] cnt_ram_rdata = '0;
  logic [3:0]            sc_is_short_vld;
  s_sc_is_short_intf     sc_is_short_intf;
  logic                  sc_is_short_last;
  logic                  is_sc_short_rd = 1'b0;
  logic                  sc_busy;

  cr_huf_comp_sc_short dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cnt_start        (cnt_start),
    .cnt_seq_id       (cnt_seq_id),
    .cnt_eob          (cnt_eob),
    .cnt_ram_rd       (cnt_ram_rd),
    .cnt_ram_addr     (cnt_ram_addr),
    .cnt_ram_rdata    (cnt_ram_rdata),
    .sc_is_short_vld  (sc_is_short_vld),
    .sc_is_short_intf (sc_is_short_intf),
    .sc_is_short_last (sc_is_short_last),
    .is_sc_short_rd   (is_sc_short_rd),
    .sc_busy          (sc_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        vld;
    logic              last;
    s_sc_is_short_intf intf;
    logic [31:0]       cyc;
  } word_t;

  logic [HC_CNT_W-1:0] mem [HC_NUM_SYM];
  word_t words [$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    rd_mode = 0;        // 0: rd held high, 1: random low bursts
  int    m_occ = 0;
  int    m_infl = 0;
  int    m_infl_addr = 0;
  int    m_exp_addr = 0;
  int    first_addr = -1;
  int    first_present = -1;
  int    start_cyc = 0;

  function automatic bit quad_kept(int q);
    bit nz = 1'b0;
    for (int i = 0; i < 4; i++) if (mem[4*q+i] != '0) nz = 1'b1;
    return nz || (q == HC_NUM_QUAD - 1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Count RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (cnt_ram_rd && int'(cnt_ram_addr) < HC_NUM_QUAD)
      for (int i = 0; i < 4; i++)
        cnt_ram_rdata[i*HC_CNT_W +: HC_CNT_W] <= mem[4*int'(cnt_ram_addr)+i];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_mode == 0) is_sc_short_rd = 1'b1;
      else is_sc_short_rd = ($urandom_range(0, 2) != 0);
      if (rd_mode == 1 && $urandom_range(0, 5) == 0) begin
        is_sc_short_rd = 1'b0;
        repeat ($urandom_range(1, 9)) begin @(posedge clk); #1; end
      end
    end
  end

  // Monitor: occupancy/credit model, address sequence, popped-word capture.
  always @(negedge clk) begin
    bit present;
    if (!rst_n) begin
      m_occ = 0; m_infl = 0; m_exp_addr = 0;
    end else begin
      present = (sc_is_short_vld != 4'b0) || sc_is_short_last;
      checks++;
      if (present !== (m_occ != 0)) begin
        errors++;
        $display("FAIL head_present: got %0b expected %0b (cyc %0d)", present, m_occ != 0, cyc);
      end
      if (present && first_present < 0) first_present = cyc;
      if (cnt_ram_rd) begin
        checks++;
        if (m_occ + m_infl > 2) begin
          errors++;
          $display("FAIL credit: occ+inflight %0d exceeds 2 at read", m_occ + m_infl);
        end
        checks++;
        if (int'(cnt_ram_addr) !== m_exp_addr) begin
          errors++;
          $display("FAIL rd_addr: got %0d expected %0d", cnt_ram_addr, m_exp_addr);
        end
        if (first_addr < 0) first_addr = int'(cnt_ram_addr);
        m_exp_addr++;
      end
      if (present && is_sc_short_rd)
        words.push_back('{vld: sc_is_short_vld, last: sc_is_short_last,
                          intf: sc_is_short_intf, cyc: 32'(cyc)});
      m_occ = m_occ + ((m_infl != 0 && quad_kept(m_infl_addr)) ? 1 : 0)
                    - ((present && is_sc_short_rd) ? 1 : 0);
      m_infl = cnt_ram_rd ? 1 : 0;
      m_infl_addr = int'(cnt_ram_addr);
    end
  end

  task automatic run_scan(input logic [3:0] seq, input logic eob, input int inject_at);
    bit done = 1'b0;
    words.delete();
    m_exp_addr = 0; first_addr = -1; first_present = -1;
    @(posedge clk); #1;
    cnt_start = 1'b1; cnt_seq_id = seq; cnt_eob = eob; start_cyc = cyc;
    @(posedge clk); #1;
    cnt_start = 1'b0; cnt_seq_id = '0; cnt_eob = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n == inject_at) begin
        cnt_start = 1'b1; cnt_seq_id = 4'd3; cnt_eob = 1'b0;
      end else begin
        cnt_start = 1'b0; cnt_seq_id = '0; cnt_eob = 1'b0;
      end
      if (!sc_busy) begin done = 1'b1; break; end
    end
    cnt_start = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL scan_timeout: busy still %0b", sc_busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cnt_ram_rd, cnt_ram_addr, sc_is_short_vld, sc_is_short_last, sc_busy} !== 15'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %0h expected 0",
               {cnt_ram_rd, cnt_ram_addr, sc_is_short_vld, sc_is_short_last, sc_busy});
    end
    checks++;
    if (sc_is_short_intf !== '0) begin
      errors++; $display("FAIL reset_intf: got %0h expected 0", sc_is_short_intf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sparse();
    foreach (mem[i]) mem[i] = '0;
    mem[5] = 20'd7; mem[575] = 20'd1;
    rd_mode = 0;
    run_scan(4'd1, 1'b1, -1);
    checks++;
    if (words.size() !== 2) begin errors++; $display("FAIL sparse_count: got %0d expected 2", words.size()); end
    if (words.size() >= 2) begin
      checks++;
      if (words[0].vld !== 4'b0010 || words[0].last !== 1'b0) begin
        errors++; $display("FAIL sparse_w0_flags: got vld %b last %b expected 0010/0", words[0].vld, words[0].last);
      end
      checks++;
      if (words[0].intf.short1 !== 10'd5 || words[0].intf.cnt1 !== 20'd7) begin
        errors++; $display("FAIL sparse_w0_data: got %0d/%0d expected 5/7", words[0].intf.short1, words[0].intf.cnt1);
      end
      checks++;
      if (words[1].vld !== 4'b1000 || words[1].last !== 1'b1) begin
        errors++; $display("FAIL sparse_w1_flags: got vld %b last %b expected 1000/1", words[1].vld, words[1].last);
      end
      checks++;
      if (words[1].intf.short3 !== 10'd575 || words[1].intf.cnt3 !== 20'd1) begin
        errors++; $display("FAIL sparse_w1_data: got %0d/%0d expected 575/1", words[1].intf.short3, words[1].intf.cnt3);
      end
      checks++;
      if (words[0].intf.seq_id !== 4'd1 || words[0].intf.eob !== 1'b1) begin
        errors++; $display("FAIL sparse_tags: got %0d/%0b expected 1/1", words[0].intf.seq_id, words[0].intf.eob);
      end
    end
    checks++;
    if (sc_busy !== 1'b0) begin errors++; $display("FAIL sparse_busy: got %0b expected 0", sc_busy); end
    checks++;
    if (first_present - start_cyc < 3) begin
      errors++; $display("FAIL head_latency: got %0d expected >= 3", first_present - start_cyc);
    end
    checks++;
    if (first_addr !== 0) begin errors++; $display("FAIL first_addr: got %0d expected 0", first_addr); end
  endtask

  task automatic test_zero();
    foreach (mem[i]) mem[i] = '0;
    rd_mode = 0;
    run_scan(4'd2, 1'b0, -1);
    checks++;
    if (words.size() !== 1) begin errors++; $display("FAIL zero_count: got %0d expected 1", words.size()); end
    if (words.size() >= 1) begin
      checks++;
      if (words[0].vld !== 4'b0000 || words[0].last !== 1'b1 || words[0].intf.short0 !== 10'd572) begin
        errors++;
        $display("FAIL zero_word: got vld %b last %b short0 %0d expected 0000/1/572",
                 words[0].vld, words[0].last, words[0].intf.short0);
      end
    end
  endtask

  task automatic test_back_to_back();
    foreach (mem[i]) mem[i] = 20'd1;
    rd_mode = 0;
    run_scan(4'd4, 1'b0, -1);
    checks++;
    if (words.size() !== 144) begin errors++; $display("FAIL b2b_count: got %0d expected 144", words.size()); end
    for (int j = 0; j < words.size(); j++) begin
      checks++;
      if (words[j].vld !== 4'hF || words[j].intf.short0 !== 10'(4*j) || words[j].intf.cnt2 !== 20'd1
          || words[j].last !== (j == 143)) begin
        errors++;
        $display("FAIL b2b_word%0d: got vld %h short0 %0d cnt2 %0d last %b expected F/%0d/1/%b",
                 j, words[j].vld, words[j].intf.short0, words[j].intf.cnt2, words[j].last, 4*j, j == 143);
      end
      if (j > 0) begin
        checks++;
        if (words[j].cyc !== words[j-1].cyc + 32'd1) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d cycles expected 1", j, words[j].cyc - words[j-1].cyc);
        end
      end
    end
  endtask

  task automatic test_random_rd();
    word_t exp_q [$];
    word_t w;
    for (int s = 0; s < HC_NUM_SYM; s++)
      mem[s] = ((s/4) % 5 == 2 || (s/4) % 7 == 3) ? 20'd0 : 20'((s * 37) % 11);
    for (int q = 0; q < HC_NUM_QUAD; q++) begin
      if (quad_kept(q)) begin
        w = '0;
        for (int i = 0; i < 4; i++) w.vld[i] = (mem[4*q+i] != '0);
        w.last = (q == HC_NUM_QUAD - 1);
        w.intf.short0 = 10'(4*q);   w.intf.short1 = 10'(4*q+1);
        w.intf.short2 = 10'(4*q+2); w.intf.short3 = 10'(4*q+3);
        w.intf.cnt0 = mem[4*q];     w.intf.cnt1 = mem[4*q+1];
        w.intf.cnt2 = mem[4*q+2];   w.intf.cnt3 = mem[4*q+3];
        w.intf.seq_id = 4'd5; w.intf.eob = 1'b0;
        exp_q.push_back(w);
      end
    end
    rd_mode = 1;
    run_scan(4'd5, 1'b0, -1);
    rd_mode = 0;
    checks++;
    if (words.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d expected %0d", words.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < words.size(); j++) begin
      checks++;
      if ({words[j].vld, words[j].last, words[j].intf} !== {exp_q[j].vld, exp_q[j].last, exp_q[j].intf}) begin
        errors++;
        $display("FAIL rand_word%0d: got %h expected %h", j,
                 {words[j].vld, words[j].last, words[j].intf}, {exp_q[j].vld, exp_q[j].last, exp_q[j].intf});
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    foreach (mem[i]) mem[i] = 20'd1;
    rd_mode = 0;
    m_exp_addr = 0;
    @(posedge clk); #1;
    cnt_start = 1'b1; cnt_seq_id = 4'd6;
    @(posedge clk); #1;
    cnt_start = 1'b0; cnt_seq_id = '0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (cnt_ram_rd && cnt_ram_addr == 8'd50) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_reach: quad 50 read not seen"); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt_ram_rd, cnt_ram_addr, sc_is_short_vld, sc_is_short_last, sc_busy} !== 15'b0
        || sc_is_short_intf !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %0h/%0h expected 0",
               {cnt_ram_rd, cnt_ram_addr, sc_is_short_vld, sc_is_short_last, sc_busy}, sc_is_short_intf);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (mem[i]) mem[i] = '0;
    run_scan(4'd2, 1'b0, -1);
    checks++;
    if (first_addr !== 0) begin errors++; $display("FAIL rst_mid_restart: got %0d expected 0", first_addr); end
    checks++;
    if (words.size() !== 1) begin errors++; $display("FAIL rst_mid_count: got %0d expected 1", words.size()); end
  endtask

  task automatic test_start_ignored();
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 20'd3; mem[100] = 20'd2; mem[300] = 20'd9;
    rd_mode = 0;
    run_scan(4'd1, 1'b1, 40);
    checks++;
    if (words.size() !== 4) begin errors++; $display("FAIL ign_count: got %0d expected 4", words.size()); end
    foreach (words[j]) begin
      checks++;
      if (words[j].intf.seq_id !== 4'd1 || words[j].intf.eob !== 1'b1) begin
        errors++; $display("FAIL ign_tags%0d: got %0d/%0b expected 1/1", j, words[j].intf.seq_id, words[j].intf.eob);
      end
    end
    if (words.size() >= 2) begin
      checks++;
      if (words[1].intf.short0 !== 10'd100 || words[1].intf.cnt0 !== 20'd2) begin
        errors++; $display("FAIL ign_w1: got %0d/%0d expected 100/2", words[1].intf.short0, words[1].intf.cnt0);
      end
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    test_reset();
    test_sparse();
    test_zero();
    test_back_to_back();
    test_random_rd();
    test_reset_mid();
    test_start_ignored();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
